// File: rtl/thr_pkg.sv
// rtl/thr_pkg.sv - shared types and helpers for the threshold config scheduler
package thr_pkg;

  localparam int THR_TYPES = 4;

  typedef enum logic [1:0] {
    Y_HI = 2'd0,
    Y_LO = 2'd1,
    CB   = 2'd2,
    CR   = 2'd3
  } thr_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ISSUE,
    ST_GAP
  } state_e;

  function automatic logic [1:0] lowest_dirty(input logic [THR_TYPES-1:0] d);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = THR_TYPES - 1; i >= 0; i--) begin
      if (d[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] popcount4(input logic [THR_TYPES-1:0] d);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < THR_TYPES; i++) begin
      n = n + {2'b00, d[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with registered last grant
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic rdy0,
  output logic rdy1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant;
  logic conflict;

  // On a conflict the port that was not granted most recently wins.
  assign conflict = req0 & req1;
  assign rdy0 = en & ~(conflict & ~last_grant);
  assign rdy1 = en & ~(conflict & last_grant);
  assign gnt0 = rdy0 & req0;
  assign gnt1 = rdy1 & req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last_grant <= gnt1;
    end
  end

endmodule

// File: rtl/threshold_cfg_sched.sv
// rtl/threshold_cfg_sched.sv - shadow threshold table replayed at frame boundaries
module threshold_cfg_sched
  import thr_pkg::*;
#(
  parameter int             DW              = 9,
  parameter logic [DW-1:0]  MAX_VAL         = 9'd255,
  parameter int             GAP             = 2,
  parameter bit             COMMIT_ON_FRAME = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_vld,
  input  logic [DW-1:0] req0_data,
  input  logic [1:0]    req0_type,
  output logic          req0_rdy,
  input  logic          req1_vld,
  input  logic [DW-1:0] req1_data,
  input  logic [1:0]    req1_type,
  output logic          req1_rdy,
  input  logic          frame_done_in,
  output logic [DW-1:0] threshold_data,
  output logic [1:0]    threshold_type,
  output logic          threshold_vld,
  output logic          commit_done,
  output logic [2:0]    pending
);

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_e                 state, state_d;
  logic [DW-1:0]          entry [THR_TYPES];
  logic [THR_TYPES-1:0]   dirty, dirty_d;
  logic [3:0]             gap_cnt;
  logic                   rdy_en;
  logic [DW-1:0]          last_data;
  logic [1:0]             last_type;
  logic                   accept_en, gnt0, gnt1, wr_en, issue, last_one;
  logic [1:0]             sel, wr_type;
  logic [DW-1:0]          wr_raw, wr_data;

  // rdy_en keeps both rdy outputs low until the first edge after reset.
  assign accept_en = rdy_en & ((state == ST_IDLE) | (state == ST_ARMED));

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (accept_en),
    .req0 (req0_vld),
    .req1 (req1_vld),
    .rdy0 (req0_rdy),
    .rdy1 (req1_rdy),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign wr_en   = gnt0 | gnt1;
  assign wr_type = gnt1 ? req1_type : req0_type;
  assign wr_raw  = gnt1 ? req1_data : req0_data;
  assign wr_data = (wr_raw > MAX_VAL) ? MAX_VAL : wr_raw;

  assign issue    = (state == ST_ISSUE);
  assign sel      = lowest_dirty(dirty);
  assign last_one = (dirty & ~(4'b0001 << sel)) == 4'b0000;

  assign threshold_vld  = issue;
  assign threshold_data = issue ? entry[sel] : last_data;
  assign threshold_type = issue ? sel : last_type;
  assign commit_done    = issue & last_one;

  always_comb begin
    dirty_d = dirty;
    if (issue) dirty_d[sel] = 1'b0;
    if (wr_en) dirty_d[wr_type] = 1'b1;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (|dirty) state_d = ST_ARMED;
      ST_ARMED: if (!COMMIT_ON_FRAME || frame_done_in) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (last_one)      state_d = ST_IDLE;
        else if (GAP == 0) state_d = ST_ISSUE;
        else               state_d = ST_GAP;
      end
      ST_GAP:   if (gap_cnt == GAP_LAST) state_d = ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dirty     <= '0;
      pending   <= 3'd0;
      gap_cnt   <= 4'd0;
      rdy_en    <= 1'b0;
      last_data <= '0;
      last_type <= 2'd0;
      for (int i = 0; i < THR_TYPES; i++) entry[i] <= '0;
    end else begin
      state   <= state_d;
      dirty   <= dirty_d;
      pending <= popcount4(dirty_d);
      rdy_en  <= 1'b1;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (issue) begin
        last_data <= entry[sel];
        last_type <= sel;
      end
      if (wr_en) entry[wr_type] <= wr_data;
    end
  end

endmodule

// File: tb/tb_threshold_cfg_sched.sv
// tb/tb_threshold_cfg_sched.sv - randomized and directed bench with a cycle-level reference model
module tb_threshold_cfg_sched;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_vld = 1'b0, req1_vld = 1'b0;
  logic [8:0] req0_data = '0, req1_data = '0;
  logic [1:0] req0_type = '0, req1_type = '0;
  logic       req0_rdy, req1_rdy;
  logic       frame_done_in = 1'b0;
  logic [8:0] threshold_data;
  logic [1:0] threshold_type;
  logic       threshold_vld, commit_done;
  logic [2:0] pending;

  threshold_cfg_sched dut (
    .clk            (clk),
    .rst            (rst),
    .req0_vld       (req0_vld),
    .req0_data      (req0_data),
    .req0_type      (req0_type),
    .req0_rdy       (req0_rdy),
    .req1_vld       (req1_vld),
    .req1_data      (req1_data),
    .req1_type      (req1_type),
    .req1_rdy       (req1_rdy),
    .frame_done_in  (frame_done_in),
    .threshold_data (threshold_data),
    .threshold_type (threshold_type),
    .threshold_vld  (threshold_vld),
    .commit_done    (commit_done),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: shadow values, staged set, and a commit schedule in absolute cycles.
  int         cyc = 0;
  bit         m_live = 0;
  bit         m_busy = 0;
  bit         m_armed = 0;
  bit         m_staged [4];
  int         m_val [4];
  bit         m_last_p1 = 1;
  int         m_next = 0;
  int         m_ld = 0;
  int         m_lt = 0;

  int pq_t[$], pq_d[$], pq_c[$], done_c[$];

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 4; i++) if (m_staged[i]) n++;
    return n;
  endfunction

  function automatic int m_low();
    for (int i = 0; i < 4; i++) if (m_staged[i]) return i;
    return 0;
  endfunction

  function automatic bit m_rdy(input int port);
    if (!m_live || m_busy) return 0;
    if (req0_vld && req1_vld) return (port == (m_last_p1 ? 0 : 1));
    return 1;
  endfunction

  always @(negedge clk) begin
    automatic bit e_vld, e_r0, e_r1, g0, g1, was_busy, was_armed, any_staged;
    automatic int s, e_d, e_t;
    if (rst) begin
      chk("rst_vld", threshold_vld, 0);
      chk("rst_done", commit_done, 0);
      chk("rst_data", threshold_data, 0);
      chk("rst_type", threshold_type, 0);
      chk("rst_pending", pending, 0);
      chk("rst_rdy0", req0_rdy, 0);
      chk("rst_rdy1", req1_rdy, 0);
      m_live = 0; m_busy = 0; m_armed = 0; m_last_p1 = 1; m_ld = 0; m_lt = 0;
      for (int i = 0; i < 4; i++) begin m_staged[i] = 0; m_val[i] = 0; end
    end else begin
      e_vld = m_busy && (cyc == m_next);
      s = m_low();
      e_d = e_vld ? m_val[s] : m_ld;
      e_t = e_vld ? s : m_lt;
      e_r0 = m_rdy(0);
      e_r1 = m_rdy(1);
      chk("vld", threshold_vld, e_vld);
      chk("data", threshold_data, e_d);
      chk("type", threshold_type, e_t);
      chk("commit_done", commit_done, e_vld && m_count() == 1);
      chk("pending", pending, m_count());
      chk("rdy0", req0_rdy, e_r0);
      chk("rdy1", req1_rdy, e_r1);
      if (threshold_vld) begin
        pq_t.push_back(threshold_type);
        pq_d.push_back(threshold_data);
        pq_c.push_back(cyc);
      end
      if (commit_done) done_c.push_back(cyc);

      g0 = req0_vld && e_r0;
      g1 = req1_vld && e_r1;
      was_busy = m_busy;
      was_armed = m_armed;
      any_staged = m_count() != 0;
      if (e_vld) begin
        m_ld = m_val[s];
        m_lt = s;
        m_staged[s] = 0;
        if (m_count() == 0) m_busy = 0;
        else m_next = cyc + GAP + 1;
      end
      if (g0) begin
        m_val[req0_type] = (req0_data > 255) ? 255 : int'(req0_data);
        m_staged[req0_type] = 1;
        m_last_p1 = 0;
      end
      if (g1) begin
        m_val[req1_type] = (req1_data > 255) ? 255 : int'(req1_data);
        m_staged[req1_type] = 1;
        m_last_p1 = 1;
      end
      if (!was_busy) begin
        if (!was_armed) begin
          if (any_staged) m_armed = 1;
        end else if (frame_done_in) begin
          m_armed = 0;
          m_busy = 1;
          m_next = cyc + 1;
        end
      end
      m_live = 1;
    end
    cyc++;
  end

  task automatic step(input bit v0, input int d0, input int t0,
                      input bit v1, input int d1, input int t1,
                      input bit fd, output bit a0, output bit a1);
    req0_vld = v0; req0_data = 9'(d0); req0_type = 2'(t0);
    req1_vld = v1; req1_data = 9'(d1); req1_type = 2'(t1);
    frame_done_in = fd;
    @(negedge clk);
    a0 = v0 && req0_rdy;
    a1 = v1 && req1_rdy;
    @(posedge clk);
    #1;
    req0_vld = 0; req1_vld = 0; frame_done_in = 0;
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, a, b);
  endtask

  task automatic wr0(input int d, input int t);
    bit a, b;
    step(1, d, t, 0, 0, 0, 0, a, b);
  endtask

  task automatic frame();
    bit a, b;
    step(0, 0, 0, 0, 0, 0, 1, a, b);
  endtask

  task automatic clear_q();
    pq_t.delete(); pq_d.delete(); pq_c.delete(); done_c.delete();
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle(1);
  endtask

  initial begin
    bit a0, a1, got;
    int tries;
    int exp_d [4];
    exp_d[0] = 220; exp_d[1] = 50; exp_d[2] = 80; exp_d[3] = 75;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rdy_low_at_release", req0_rdy, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rdy_high_after_edge", req0_rdy, 1);
    @(posedge clk);
    #1;

    clear_q();
    wr0(220, 0); wr0(50, 1); wr0(80, 2); wr0(75, 3);
    chk("t1_pending4", pending, 4);
    frame();
    idle(14);
    chk("t1_npulses", pq_t.size(), 4);
    if (pq_t.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_type", pq_t[i], i);
        chk("t1_data", pq_d[i], exp_d[i]);
        if (i > 0) chk("t1_spacing", pq_c[i] - pq_c[i-1], 3);
      end
      chk("t1_done_on_last", (done_c.size() == 1) ? done_c[0] : -1, pq_c[3]);
    end
    chk("t1_pending0", pending, 0);

    do_reset();
    clear_q();
    step(1, 10, 1, 1, 20, 1, 0, a0, a1);
    chk("t2_c1_rdy0", a0, 1);
    chk("t2_c1_rdy1", a1, 0);
    idle(1); frame(); idle(6);
    chk("t2_c1_pulses", pq_d.size(), 1);
    if (pq_d.size() == 1) chk("t2_c1_data", pq_d[0], 10);
    clear_q();
    step(1, 10, 1, 1, 20, 1, 0, a0, a1);
    chk("t2_c2_rdy0", a0, 0);
    chk("t2_c2_rdy1", a1, 1);
    idle(1); frame(); idle(6);
    chk("t2_c2_pulses", pq_d.size(), 1);
    if (pq_d.size() == 1) chk("t2_c2_data", pq_d[0], 20);

    clear_q();
    wr0(400, 2);
    chk("t3_pending1", pending, 1);
    idle(1); frame(); idle(6);
    chk("t3_pulses", pq_d.size(), 1);
    if (pq_d.size() == 1) begin
      chk("t3_sat", pq_d[0], 255);
      chk("t3_type", pq_t[0], 2);
    end

    clear_q();
    wr0(30, 1); wr0(60, 1);
    chk("t4_pending1", pending, 1);
    frame(); idle(6);
    chk("t4_pulses", pq_d.size(), 1);
    if (pq_d.size() == 1) chk("t4_last_wins", pq_d[0], 60);

    idle(2);
    clear_q();
    frame(); idle(8);
    chk("t5_frame_no_dirty", pq_d.size(), 0);

    clear_q();
    wr0(5, 0); wr0(7, 3);
    frame(); idle(1); frame(); idle(8);
    chk("t5_frame_in_gap", pq_d.size(), 2);

    clear_q();
    wr0(11, 0); wr0(22, 2);
    frame();
    got = 0;
    tries = 0;
    while (!got && tries < 20) begin
      step(1, 99, 3, 0, 0, 0, 0, a0, a1);
      if (tries == 0) chk("t5_rdy_in_issue", a0, 0);
      got = a0;
      tries++;
    end
    chk("t5_accept_after_commit", got, 1);
    idle(1); frame(); idle(6);
    chk("t5_pulses", pq_d.size(), 3);
    if (pq_d.size() == 3) begin
      chk("t5_late_data", pq_d[2], 99);
      chk("t5_late_type", pq_t[2], 3);
    end

    clear_q();
    wr0(1, 0); wr0(2, 1); wr0(3, 2); wr0(4, 3);
    frame(); idle(5);
    chk("t6_before_rst_pulses", pq_d.size(), 2);
    chk("t6_before_rst_pending", pending, 2);
    rst = 1;
    #1;
    chk("t6_rst_vld", threshold_vld, 0);
    chk("t6_rst_pending", pending, 0);
    chk("t6_rst_data", threshold_data, 0);
    chk("t6_rst_rdy", req0_rdy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle(20);
    chk("t6_no_pulse_after_rst", pq_d.size(), 2);

    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 511), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), $urandom_range(0, 511), $urandom_range(0, 3),
           $urandom_range(0, 7) == 0, a0, a1);
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
